piso: RTL and testbench
=======================

// Module: piso
// PURPOSE
//  Parallel-in serial-out shifter: accepts a WIDTH-bit word over a valid/ready
//  load handshake and emits it on a single-bit serial line, MSB first, one bit/clk.
//  Transmit-side counterpart to the serial-in parallel-out shift register.
//  A serial-to-parallel register sampling s_out while s_valid=1 reconstructs the word.
//  Supports back-to-back words with no idle gap between them.
// PARAMETERS
//  WIDTH  4  parallel word width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-high reset
//  p_in       in   WIDTH  parallel word; sampled on the accept edge only
//  load_valid in   1      source presents p_in
//  load_ready out  1      piso can take a word this cycle
//  s_out      out  1      serial data bit
//  s_valid    out  1      s_out carries a live bit this cycle
//  s_last     out  1      final bit of the current word frame
//  s_par      out  1      current bit is the parity bit (0 without PISO_PARITY_EN)
//  busy       out  1      a frame is in progress (= s_valid)
// BEHAVIOUR
//  - States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
//    Internal state: shreg[WIDTH-1:0] and cnt[$clog2(WIDTH)-1:0].
//  - Reset (reset=1 at posedge): state=IDLE, shreg=0, cnt=0. It overrides every
//    other input, including an accept in the same cycle.
//    Reset mid-frame abandons the word; no partial bits after the reset edge.
//  - Outputs are decoded from registers only (no comb path from inputs except load_ready):
//    - IDLE: s_out=0, s_valid=0, s_last=0, s_par=0, load_ready=1.
//    - SHIFT: s_out=shreg[WIDTH-1], s_valid=1, s_last=(cnt==0) [w/o macro],
//      load_ready=s_last.
//  - Accept = load_valid & load_ready at posedge.
//    On accept: shreg<=p_in, cnt<=WIDTH-1, state<=SHIFT.
//  - Latency: MSB appears on s_out in the cycle after the accept edge.
//    A frame occupies WIDTH cycles (WIDTH+1 with parity).
//  - SHIFT edge with cnt!=0: shreg<=shreg<<1 (LSB filled with 0), cnt<=cnt-1.
//  - SHIFT edge with cnt==0 (w/o macro):
//    - Accept in the same cycle: reload (no gap).
//    - Otherwise: return to IDLE.
//  - load_valid while load_ready=0: ignored and not sampled; the source holds
//    the word until accepted.
//    Changes to p_in mid-frame have no effect on the frame in flight.
//  - cnt never wraps: it is only decremented while nonzero.
// CONFIGURATION
//  Macro PISO_PARITY_EN (`ifdef):
//  - Defined:
//    - Accept also captures par = ^p_in (even parity).
//    - SHIFT with cnt==0 always moves to PARITY.
//    - In SHIFT: s_last=0 and load_ready=0 (in IDLE load_ready stays 1).
//    - PARITY cycle: s_out=par, s_valid=1, s_par=1, s_last=1, load_ready=1.
//    - PARITY edge: accept -> SHIFT with a new word; else -> IDLE.
//    - Reset clears par.
//  - Undefined: PARITY state and par register absent; s_par tied 0;
//    frame = WIDTH bits.
// TESTING
//  1. reset 2 clk, load 4'b1011 -> s_out 1,0,1,1 with s_valid=1 for 4 cycles;
//     s_last on 4th; then IDLE.
//  2. load_valid held, 4'hA then 4'h5 -> 8 contiguous bits 1,0,1,0,0,1,0,1;
//     no s_valid gap; load_ready pulses on each s_last.
//  3. s_out feeds a 4-bit left-shift serial-to-parallel model enabled by s_valid,
//     word 4'hC -> model holds 4'hC the cycle after s_last.
//  4. reset asserted after 2 bits of 4'hF -> next cycle s_valid=0, s_out=0,
//     load_ready=1, busy=0.
//  5. mid-frame load_valid=1 with p_in=4'h3 while sending 4'h9 -> bits stay 1,0,0,1;
//     4'h3 accepted only on the s_last cycle.
//  6. PISO_PARITY_EN, load 4'b1011 -> 1,0,1,1 then parity bit 1 with s_par=1 and s_last=1;
//     load 4'b0011 -> parity bit 0.

Source files
------------

// File: rtl/piso.sv
// piso -- parallel-in serial-out shifter, MSB first, one bit per clock.
//
// A WIDTH-bit word is taken over a valid/ready handshake and emitted on
// s_out. The load_ready signal rises on the final bit of a frame, so a
// held load_valid chains words with no idle cycle between them.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// after the data bits. In that case the frame is WIDTH+1 cycles long and
// s_par/s_last mark the parity cycle.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-high reset
//   p_in       in   parallel word, sampled only on the accept edge
//   load_valid in   source presents p_in
//   load_ready out  piso can take a word this cycle
//   s_out      out  serial data bit
//   s_valid    out  s_out carries a live bit
//   s_last     out  final bit of the current frame
//   s_par      out  current bit is the parity bit (0 without PISO_PARITY_EN)
//   busy       out  frame in progress (same as s_valid)
module piso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             s_par,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             accept;
  logic             cnt_zero;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
`endif

  assign cnt_zero = (cnt_q == '0);

  // Output decode: registers only, so no input reaches any output.
  always_comb begin
    s_out      = 1'b0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    s_par      = 1'b0;
    load_ready = 1'b0;
    case (state_q)
      IDLE: load_ready = 1'b1;
      SHIFT: begin
        s_out   = shreg_q[WIDTH-1];
        s_valid = 1'b1;
`ifndef PISO_PARITY_EN
        // Ready on the last bit lets the next word follow with no gap.
        s_last     = cnt_zero;
        load_ready = cnt_zero;
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        s_out      = par_q;
        s_valid    = 1'b1;
        s_par      = 1'b1;
        s_last     = 1'b1;
        load_ready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy   = s_valid;
  assign accept = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (!cnt_zero) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CW'(1);
        end else begin
`ifdef PISO_PARITY_EN
          state_d = PARITY;
`else
          // Without an accept the frame ends; the accept case reloads below.
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // load_ready is only high in states where a reload is legal, so an
    // accept always wins over the state's own transition.
    if (accept) begin
      shreg_d = p_in;
      cnt_d   = CW'(WIDTH - 1);
      state_d = SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = ^p_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso.sv
// tb_piso -- self-checking bench for piso (WIDTH=4).
// Reference model: a queue holding the bits still to be sent for the
// current frame. Outputs follow from the queue contents; an accepted word
// replaces the queue with its bits (plus parity when PISO_PARITY_EN).
module tb_piso;

`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] p_in = 4'h0;
  logic       load_ready, s_out, s_valid, s_last, s_par, busy;
  logic [5:0] obs;

  int checks = 0;
  int fails  = 0;
  bit q[$];

  piso #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .p_in(p_in), .load_valid(load_valid),
    .load_ready(load_ready), .s_out(s_out), .s_valid(s_valid),
    .s_last(s_last), .s_par(s_par), .busy(busy)
  );

  always #5 clk = ~clk;

  assign obs = {s_out, s_valid, s_last, s_par, busy, load_ready};

  // {s_out, s_valid, s_last, s_par, busy, load_ready}
  function automatic logic [5:0] exp_out();
    if (q.size() == 0) return 6'b000001;
    return {q[0], 1'b1, q.size() == 1, PAR_EN && q.size() == 1, 1'b1, q.size() <= 1};
  endfunction

  function automatic bit model_ready();
    return q.size() <= 1;
  endfunction

  // Drive one cycle and advance the model; returns at the next negedge.
  task automatic tick(input bit rst, input bit lv, input logic [3:0] p);
    bit rdy;
    rdy = model_ready();
    reset = rst; load_valid = lv; p_in = p;
    if (rst) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (lv && rdy) begin
        q.delete();
        for (int i = 3; i >= 0; i--) q.push_back(p[i]);
        if (PAR_EN) q.push_back(^p);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1, 0, 4'h0);
    tick(1, 0, 4'h0);
    checks++;
    if (obs !== 6'b000001) begin fails++; $display("FAIL reset_idle: got %b want %b", obs, 6'b000001); end
    // Reset beats an accept in the same cycle.
    tick(1, 1, 4'hF);
    checks++;
    if (obs !== exp_out()) begin fails++; $display("FAIL reset_over_accept: got %b want %b", obs, exp_out()); end
    tick(0, 0, 4'h0);
  endtask

  task automatic test_single();
    logic [3:0] w;
    w = 4'hB;
    tick(0, 1, w);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL single cyc%0d: got %b want %b", i, obs, exp_out()); end
      if (i < 4) begin
        checks++;
        if (s_out !== w[3-i] || s_valid !== 1'b1) begin
          fails++; $display("FAIL single_bit%0d: got %b/%b want %b/1", i, s_out, s_valid, w[3-i]);
        end
      end
      tick(0, 0, 4'h0);
    end
  endtask

  task automatic test_back_to_back();
    bit got[$];
    bit want[$];
    bit sent2;
    logic [3:0] w1, w2;
    w1 = 4'hA; w2 = 4'h5; sent2 = 0;
    for (int i = 3; i >= 0; i--) want.push_back(w1[i]);
    if (PAR_EN) want.push_back(^w1);
    for (int i = 3; i >= 0; i--) want.push_back(w2[i]);
    if (PAR_EN) want.push_back(^w2);
    tick(0, 1, w1);
    for (int i = 0; i < want.size(); i++) begin
      bit r;
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL b2b cyc%0d: got %b want %b", i, obs, exp_out()); end
      got.push_back(s_valid ? s_out : 1'bx);
      r = model_ready();
      tick(0, !sent2, w2);
      if (r) sent2 = 1;
    end
    for (int i = 0; i < want.size(); i++) begin
      checks++;
      if (got[i] !== want[i]) begin fails++; $display("FAIL b2b_stream bit%0d: got %b want %b", i, got[i], want[i]); end
    end
    tick(0, 0, 4'h0);
  endtask

  task automatic test_sipo();
    logic [3:0] sipo;
    bit last;
    sipo = 4'h0; last = 0;
    tick(0, 1, 4'hC);
    for (int i = 0; i < 8 && !last; i++) begin
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL sipo cyc%0d: got %b want %b", i, obs, exp_out()); end
      if (s_valid && !s_par) sipo = {sipo[2:0], s_out};
      last = s_last;
      tick(0, 0, 4'h0);
    end
    checks++;
    if (sipo !== 4'hC || !last) begin fails++; $display("FAIL sipo_word: got %h want c (last=%0b)", sipo, last); end
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 4'hF);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL rmid cyc%0d: got %b want %b", i, obs, exp_out()); end
      tick(0, 0, 4'h0);
    end
    tick(1, 0, 4'h0);
    checks++;
    if (obs !== 6'b000001) begin fails++; $display("FAIL rmid_abort: got %b want %b", obs, 6'b000001); end
    tick(0, 0, 4'h0);
    checks++;
    if (obs !== exp_out()) begin fails++; $display("FAIL rmid_after: got %b want %b", obs, exp_out()); end
  endtask

  task automatic test_midframe();
    logic [3:0] w;
    bit acc;
    w = 4'h9; acc = 0;
    tick(0, 1, w);
    for (int i = 0; i < 12; i++) begin
      bit r;
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL midf cyc%0d: got %b want %b", i, obs, exp_out()); end
      if (i < 4) begin
        checks++;
        if (s_out !== w[3-i]) begin fails++; $display("FAIL midf_bit%0d: got %b want %b", i, s_out, w[3-i]); end
      end
      r = model_ready();
      if (!acc && r) begin
        checks++;
        if (i != 3 + int'(PAR_EN) || load_ready !== 1'b1) begin
          fails++; $display("FAIL midf_accept_cycle: got cyc%0d ready=%b want cyc%0d", i, load_ready, 3 + int'(PAR_EN));
        end
      end
      tick(0, !acc, 4'h3);
      if (r) acc = 1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit rst, lv;
      logic [3:0] p;
      rst = ($urandom_range(0, 39) == 0);
      lv  = ($urandom_range(0, 2) != 0);
      p   = 4'($urandom);
      checks++;
      if (obs !== exp_out()) begin fails++; $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_out()); end
      tick(rst, lv, p);
    end
    tick(1, 0, 4'h0);
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [3:0] words [2];
    words[0] = 4'b1011; words[1] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      tick(0, 1, words[k]);
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (obs !== exp_out()) begin fails++; $display("FAIL par%0d cyc%0d: got %b want %b", k, i, obs, exp_out()); end
        if (i == 4) begin
          checks++;
          if (s_out !== (k == 0 ? 1'b1 : 1'b0) || s_par !== 1'b1 || s_last !== 1'b1) begin
            fails++; $display("FAIL par%0d_bit: got out=%b par=%b last=%b want out=%0d par=1 last=1", k, s_out, s_par, s_last, k == 0);
          end
        end
        tick(0, 0, 4'h0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sipo();
    test_reset_mid();
    test_midframe();
    test_random();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
